// File: rtl/niu_mc_alu_if.sv
// Start/busy/done operand and result bundle for the Niu32 multicycle ALU.
// The master drives the request side; the ALU (slave) drives status and results.
interface niu_mc_alu_if #(
  parameter int WORD_SIZE = 32,
  parameter int OP_BITS   = 5
);
  logic                 start;
  logic [OP_BITS-1:0]   func;
  logic [WORD_SIZE-1:0] a;
  logic [WORD_SIZE-1:0] b;
  logic                 busy;
  logic                 done;
  logic [WORD_SIZE-1:0] result;
  logic [WORD_SIZE-1:0] rem;
  logic                 div_zero;
  logic                 illegal;

  modport master (
    output start, func, a, b,
    input  busy, done, result, rem, div_zero, illegal
  );

  modport slave (
    input  start, func, a, b,
    output busy, done, result, rem, div_zero, illegal
  );
endinterface

// File: rtl/niu_mc_alu.sv
// Multicycle ALU: single-cycle ops finish 1 cycle after accept, MLT/DIV WORD_SIZE+1 cycles.
// Backpressure: start is sampled only while busy=0; a start during busy is dropped, not queued.
module niu_mc_alu #(
  parameter int WORD_SIZE  = 32,
  parameter int OP_BITS    = 5,
  parameter int SHAMT_BITS = $clog2(WORD_SIZE)
) (
  input logic         clk,
  input logic         reset,
  niu_mc_alu_if.slave alu
);
  localparam int CNT_BITS = $clog2(WORD_SIZE + 1);

  localparam logic [OP_BITS-1:0] OP_SUB = OP_BITS'(5'b00000);
  localparam logic [OP_BITS-1:0] OP_ADD = OP_BITS'(5'b00001);
  localparam logic [OP_BITS-1:0] OP_MLT = OP_BITS'(5'b00010);
  localparam logic [OP_BITS-1:0] OP_DIV = OP_BITS'(5'b00011);
  localparam logic [OP_BITS-1:0] OP_NOT = OP_BITS'(5'b00100);
  localparam logic [OP_BITS-1:0] OP_AND = OP_BITS'(5'b00101);
  localparam logic [OP_BITS-1:0] OP_OR  = OP_BITS'(5'b00110);
  localparam logic [OP_BITS-1:0] OP_XOR = OP_BITS'(5'b00111);
  localparam logic [OP_BITS-1:0] OP_SUL = OP_BITS'(5'b01000);
  localparam logic [OP_BITS-1:0] OP_SSL = OP_BITS'(5'b01001);
  localparam logic [OP_BITS-1:0] OP_SUR = OP_BITS'(5'b01010);
  localparam logic [OP_BITS-1:0] OP_SSR = OP_BITS'(5'b01011);
  localparam logic [OP_BITS-1:0] OP_EQ  = OP_BITS'(5'b10000);
  localparam logic [OP_BITS-1:0] OP_NEQ = OP_BITS'(5'b10001);
  localparam logic [OP_BITS-1:0] OP_LT  = OP_BITS'(5'b10010);
  localparam logic [OP_BITS-1:0] OP_LEQ = OP_BITS'(5'b10011);

  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

  state_t               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WORD_SIZE-1:0] acc_q, acc_d;
  logic [WORD_SIZE-1:0] quo_q, quo_d;
  logic [WORD_SIZE-1:0] opnd_q, opnd_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic [WORD_SIZE-1:0] rem_q, rem_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;
  logic                 illegal_q, illegal_d;

  logic signed [WORD_SIZE-1:0] sa, sb;
  logic [SHAMT_BITS-1:0]       shamt;
  logic [WORD_SIZE-1:0]        mag_a, mag_b, single_res, rsh;
  logic                        legal, op_div, op_iter;

  assign sa      = alu.a;
  assign sb      = alu.b;
  assign shamt   = alu.b[SHAMT_BITS-1:0];
  assign mag_a   = alu.a[WORD_SIZE-1] ? -alu.a : alu.a;
  assign mag_b   = alu.b[WORD_SIZE-1] ? -alu.b : alu.b;
  assign op_div  = (alu.func == OP_DIV);
  assign op_iter = (alu.func == OP_MLT) || (op_div && (alu.b != '0));
  // Partial remainder stays below the divisor magnitude, so its MSB is always clear.
  assign rsh     = {acc_q[WORD_SIZE-2:0], quo_q[WORD_SIZE-1]};

  always_comb begin
    single_res = '0;
    legal      = 1'b1;
    case (alu.func)
      OP_SUB:         single_res = alu.a - alu.b;
      OP_ADD:         single_res = alu.a + alu.b;
      OP_NOT:         single_res = ~alu.a;
      OP_AND:         single_res = alu.a & alu.b;
      OP_OR:          single_res = alu.a | alu.b;
      OP_XOR:         single_res = alu.a ^ alu.b;
      OP_SUL, OP_SSL: single_res = alu.a << shamt;
      OP_SUR:         single_res = alu.a >> shamt;
      OP_SSR:         single_res = $unsigned(sa >>> shamt);
      OP_EQ:          single_res = WORD_SIZE'(sa == sb);
      OP_NEQ:         single_res = WORD_SIZE'(sa != sb);
      OP_LT:          single_res = WORD_SIZE'(sa < sb);
      OP_LEQ:         single_res = WORD_SIZE'(sa <= sb);
      OP_MLT, OP_DIV: single_res = '0;
      default:        legal      = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    acc_d      = acc_q;
    quo_d      = quo_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (alu.start) begin
          if (op_iter) begin
            state_d   = ITER;
            cnt_d     = CNT_BITS'(WORD_SIZE);
            is_div_d  = op_div;
            neg_quo_d = alu.a[WORD_SIZE-1] ^ alu.b[WORD_SIZE-1];
            neg_rem_d = alu.a[WORD_SIZE-1];
            acc_d     = '0;
            quo_d     = op_div ? mag_a : mag_b;
            opnd_d    = op_div ? mag_b : mag_a;
          end else begin
            done_d = 1'b1;
            if (op_div) begin
              result_d   = '1;
              rem_d      = alu.a;
              div_zero_d = 1'b1;
            end else begin
              result_d  = single_res;
              rem_d     = '0;
              illegal_d = !legal;
            end
          end
        end
      end
      ITER: begin
        cnt_d = cnt_q - CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(1)) state_d = FINISH;
        if (is_div_q) begin
          if (rsh >= opnd_q) begin
            acc_d = rsh - opnd_q;
            quo_d = {quo_q[WORD_SIZE-2:0], 1'b1};
          end else begin
            acc_d = rsh;
            quo_d = {quo_q[WORD_SIZE-2:0], 1'b0};
          end
        end else begin
          acc_d  = quo_q[0] ? acc_q + opnd_q : acc_q;
          opnd_d = opnd_q << 1;
          quo_d  = quo_q >> 1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          result_d = neg_quo_q ? -quo_q : quo_q;
          rem_d    = neg_rem_q ? -acc_q : acc_q;
        end else begin
          result_d = neg_quo_q ? -acc_q : acc_q;
          rem_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      acc_q      <= '0;
      quo_q      <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      acc_q      <= acc_d;
      quo_q      <= quo_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      illegal_q  <= illegal_d;
    end
  end

  assign alu.busy     = (state_q != IDLE);
  assign alu.done     = done_q;
  assign alu.result   = result_q;
  assign alu.rem      = rem_q;
  assign alu.div_zero = div_zero_q;
  assign alu.illegal  = illegal_q;
endmodule

// File: tb/tb_niu_mc_alu.sv
// Bench for niu_mc_alu: a 32-bit and an 8-bit instance checked every cycle
// against an arithmetic reference model and a timing scoreboard.
module tb_niu_mc_alu;
  localparam logic [4:0] F_SUB = 5'b00000, F_ADD = 5'b00001, F_MLT = 5'b00010, F_DIV = 5'b00011;
  localparam logic [4:0] F_NOT = 5'b00100, F_AND = 5'b00101, F_OR  = 5'b00110, F_XOR = 5'b00111;
  localparam logic [4:0] F_SUL = 5'b01000, F_SSL = 5'b01001, F_SUR = 5'b01010, F_SSR = 5'b01011;
  localparam logic [4:0] F_EQ  = 5'b10000, F_NEQ = 5'b10001, F_LT  = 5'b10010, F_LEQ = 5'b10011;

  typedef struct {
    int          dut;
    int          due;
    logic [31:0] res;
    logic [31:0] rm;
    logic        dz;
    logic        il;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  int   free_edge[2] = '{0, 0};
  int   busy_lo[2]   = '{1, 1};
  int   busy_hi[2]   = '{0, 0};
  logic [31:0] last_res[2] = '{0, 0};
  logic [31:0] last_rem[2] = '{0, 0};

  niu_mc_alu_if #(.WORD_SIZE(32), .OP_BITS(5)) if32 ();
  niu_mc_alu_if #(.WORD_SIZE(8),  .OP_BITS(5)) if8 ();

  niu_mc_alu #(.WORD_SIZE(32)) dut32 (.clk(clk), .reset(reset), .alu(if32.slave));
  niu_mc_alu #(.WORD_SIZE(8))  dut8  (.clk(clk), .reset(reset), .alu(if8.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic on sign-extended integers, masked back to w bits.
  function automatic void model(input int w, input logic [4:0] f, input logic [31:0] ai,
                                input logic [31:0] bi, output logic [31:0] res,
                                output logic [31:0] rm, output logic dz, output logic il,
                                output logic it);
    longint mask, sa, sb_, r, m;
    int sh;
    mask = (longint'(1) << w) - 1;
    sa = longint'(ai) & mask;
    sb_ = longint'(bi) & mask;
    if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
    if (sb_ >= (longint'(1) << (w - 1))) sb_ = sb_ - (longint'(1) << w);
    sh = int'(bi % w);
    r = 0; m = 0; dz = 1'b0; il = 1'b0; it = 1'b0;
    case (f)
      F_SUB: r = sa - sb_;
      F_ADD: r = sa + sb_;
      F_MLT: begin r = sa * sb_; it = 1'b1; end
      F_DIV: begin
        if (sb_ == 0) begin r = -1; m = sa; dz = 1'b1; end
        else begin r = sa / sb_; m = sa % sb_; it = 1'b1; end
      end
      F_NOT: r = ~sa;
      F_AND: r = sa & sb_;
      F_OR:  r = sa | sb_;
      F_XOR: r = sa ^ sb_;
      F_SUL, F_SSL: r = sa << sh;
      F_SUR: r = (sa & mask) >> sh;
      F_SSR: r = sa >>> sh;
      F_EQ:  r = (sa == sb_) ? 1 : 0;
      F_NEQ: r = (sa != sb_) ? 1 : 0;
      F_LT:  r = (sa < sb_) ? 1 : 0;
      F_LEQ: r = (sa <= sb_) ? 1 : 0;
      default: il = 1'b1;
    endcase
    res = 32'(r & mask);
    rm  = 32'(m & mask);
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (dut%0d, cycle %0d): got %h, expected %h", name, d, cyc, act, req);
    end
  endtask

  // Drives one request for one cycle; the scoreboard gets an entry only if the model accepts it.
  task automatic issue(input int d, input logic [4:0] f, input logic [31:0] av, input logic [31:0] bv);
    int w, e0;
    logic [31:0] r, rm;
    logic dz, il, it;
    exp_t e;
    w = (d == 0) ? 32 : 8;
    e0 = cyc + 1;
    if (d == 0) begin
      if32.start = 1'b1; if32.func = f; if32.a = av; if32.b = bv;
    end else begin
      if8.start = 1'b1; if8.func = f; if8.a = av[7:0]; if8.b = bv[7:0];
    end
    if (e0 >= free_edge[d]) begin
      model(w, f, av, bv, r, rm, dz, il, it);
      e.dut = d; e.due = it ? e0 + w + 1 : e0;
      e.res = r; e.rm = rm; e.dz = dz; e.il = il;
      sb.push_back(e);
      if (it) begin
        busy_lo[d] = e0; busy_hi[d] = e0 + w; free_edge[d] = e0 + w + 2;
      end else begin
        free_edge[d] = e0 + 1;
      end
    end
    @(posedge clk); #1;
    if32.start = 1'b0; if32.func = 5'($urandom); if32.a = $urandom; if32.b = $urandom;
    if8.start  = 1'b0; if8.func  = 5'($urandom); if8.a  = 8'($urandom); if8.b  = 8'($urandom);
  endtask

  task automatic wait_until(input int edge_no);
    while (cyc + 1 < edge_no) begin
      @(posedge clk); #1;
    end
  endtask

  // Compare process: model literals first, then every cycle against the scoreboard.
  initial begin
    logic [31:0] r, rm;
    logic dz, il, it;
    model(32, F_ADD, 32'd7, 32'hFFFF_FFFD, r, rm, dz, il, it);  chk("lit_add", -1, r, 32'd4);
    model(32, F_SUB, 32'd0, 32'd1, r, rm, dz, il, it);          chk("lit_sub", -1, r, 32'hFFFF_FFFF);
    model(32, F_MLT, 32'hFFFF_FFFA, 32'd7, r, rm, dz, il, it);  chk("lit_mlt", -1, r, 32'hFFFF_FFD6);
    model(32, F_MLT, 32'h0001_0000, 32'h0001_0000, r, rm, dz, il, it); chk("lit_mlt_wrap", -1, r, 32'd0);
    model(32, F_DIV, 32'hFFFF_FFEF, 32'd5, r, rm, dz, il, it);  chk("lit_div_q", -1, r, 32'hFFFF_FFFD);
    chk("lit_div_r", -1, rm, 32'hFFFF_FFFE);
    model(32, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, rm, dz, il, it); chk("lit_minint", -1, r, 32'h8000_0000);
    model(32, F_DIV, 32'd9, 32'd0, r, rm, dz, il, it);
    chk("lit_dz_q", -1, r, 32'hFFFF_FFFF); chk("lit_dz_r", -1, rm, 32'd9); chk("lit_dz_f", -1, 32'(dz), 32'd1);
    model(32, F_SSR, 32'h8000_0000, 32'h24, r, rm, dz, il, it); chk("lit_ssr", -1, r, 32'hF800_0000);
    model(32, F_SUR, 32'h8000_0000, 32'h24, r, rm, dz, il, it); chk("lit_sur", -1, r, 32'h0800_0000);
    model(32, F_LT, 32'hFFFF_FFFF, 32'd1, r, rm, dz, il, it);   chk("lit_lt", -1, r, 32'd1);
    model(32, F_LEQ, 32'd5, 32'd5, r, rm, dz, il, it);          chk("lit_leq", -1, r, 32'd1);
    model(32, 5'b11111, 32'd3, 32'd4, r, rm, dz, il, it);
    chk("lit_ill_r", -1, r, 32'd0); chk("lit_ill_f", -1, 32'(il), 32'd1);
    model(8, F_MLT, 32'hFFFF_FFFC, 32'd3, r, rm, dz, il, it);   chk("lit_mlt8", -1, r, 32'h0000_00F4);
    model(8, F_SSL, 32'h01, 32'h0F, r, rm, dz, il, it);         chk("lit_ssl8", -1, r, 32'h0000_0080);
    forever begin
      logic s_done[2], s_busy[2], s_dz[2], s_il[2];
      logic [31:0] s_res[2], s_rem[2];
      @(negedge clk);
      s_done[0] = if32.done; s_busy[0] = if32.busy; s_dz[0] = if32.div_zero; s_il[0] = if32.illegal;
      s_res[0] = if32.result; s_rem[0] = if32.rem;
      s_done[1] = if8.done; s_busy[1] = if8.busy; s_dz[1] = if8.div_zero; s_il[1] = if8.illegal;
      s_res[1] = {24'd0, if8.result}; s_rem[1] = {24'd0, if8.rem};
      if (reset) begin
        sb.delete();
        last_res = '{0, 0};
        last_rem = '{0, 0};
      end
      for (int d = 0; d < 2; d++) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (sb[i].dut == d && sb[i].due == cyc) idx = i;
        chk("done", d, 32'(s_done[d]), 32'(idx >= 0));
        chk("busy", d, 32'(s_busy[d]), 32'(cyc >= busy_lo[d] && cyc <= busy_hi[d]));
        if (idx >= 0) begin
          chk("result", d, s_res[d], sb[idx].res);
          chk("rem", d, s_rem[d], sb[idx].rm);
          chk("div_zero", d, 32'(s_dz[d]), 32'(sb[idx].dz));
          chk("illegal", d, 32'(s_il[d]), 32'(sb[idx].il));
          last_res[d] = sb[idx].res;
          last_rem[d] = sb[idx].rm;
          sb.delete(idx);
        end else begin
          chk("result_hold", d, s_res[d], last_res[d]);
          chk("rem_hold", d, s_rem[d], last_rem[d]);
          chk("flags_idle", d, {30'd0, s_dz[d], s_il[d]}, 32'd0);
        end
      end
    end
  end

  // Driver: directed vectors on a fixed schedule derived from the model's accept times.
  initial begin
    int e0;
    if32.start = 1'b0; if32.func = '0; if32.a = '0; if32.b = '0;
    if8.start  = 1'b0; if8.func  = '0; if8.a  = '0; if8.b  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    issue(0, F_ADD, 32'd7, 32'hFFFF_FFFD);
    issue(0, F_SUB, 32'd0, 32'd1);
    issue(0, F_MLT, 32'hFFFF_FFFA, 32'd7);
    wait_until(free_edge[0]);
    issue(0, F_MLT, 32'h0001_0000, 32'h0001_0000);
    wait_until(free_edge[0]);
    issue(0, F_DIV, 32'hFFFF_FFEF, 32'd5);
    e0 = cyc;
    wait_until(e0 + 5);
    issue(0, F_ADD, 32'd100, 32'd200);
    wait_until(free_edge[0]);
    issue(0, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_until(free_edge[0]);
    issue(0, F_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_until(free_edge[0]);
    issue(0, F_DIV, 32'd9, 32'd0);
    issue(0, F_SSR, 32'h8000_0000, 32'h24);
    issue(0, F_SUR, 32'h8000_0000, 32'h24);
    issue(0, F_LT,  32'hFFFF_FFFF, 32'd1);
    issue(0, F_LEQ, 32'd5, 32'd5);
    issue(0, 5'b11111, 32'd3, 32'd4);
    issue(0, F_NOT, 32'h0F0F_1234, 32'd0);
    issue(0, F_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    issue(0, F_OR,  32'hFF00_FF00, 32'h0FF0_0FF0);
    issue(0, F_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0);
    issue(0, F_SUL, 32'h0000_0003, 32'hFFFF_FFE4);
    issue(0, F_EQ,  32'd5, 32'd5);
    issue(0, F_NEQ, 32'd5, 32'd5);
    issue(0, F_LT,  32'd1, 32'hFFFF_FFFF);

    issue(0, F_MLT, 32'd3, 32'd5);
    e0 = cyc;
    wait_until(e0 + 10);
    reset = 1'b1;
    busy_lo = '{1, 1}; busy_hi = '{0, 0}; free_edge = '{0, 0};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    issue(0, F_ADD, 32'd2, 32'd2);

    issue(1, F_MLT, 32'hFFFF_FFFC, 32'd3);
    wait_until(free_edge[1]);
    issue(1, F_SSL, 32'h01, 32'h0F);
    issue(1, F_DIV, 32'h80, 32'hFF);
    wait_until(free_edge[1]);
    issue(1, F_DIV, 32'd100, 32'd7);
    wait_until(free_edge[1]);
    issue(1, F_SSR, 32'h90, 32'h03);

    repeat (45) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/niu_mc_alu.md
Name: niu_mc_alu

Overview:
- Parametrised multicycle ALU for the Niu32 datapath; next generation of the single-cycle bus ALU.
- Executes the full OP2 function set on latched operands:
  - single-cycle ops complete in 1 cycle;
  - MLT/DIV run iteratively, one bit per cycle.
- Uses a start/busy/done handshake so the control FSM can stall for long ops.
- Produces a remainder and error flags, which the previous ALU lacked.

Parameters:
- WORD_SIZE, 32, operand/result width in bits; any value ≥ 4.
- OP_BITS, 5, width of the function select.
- SHAMT_BITS, $clog2(WORD_SIZE), number of low bits of b used as the shift amount.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  request; sampled only while busy=0.
- func  input  OP_BITS  function code, OP2 encoding.
- a  input  WORD_SIZE  operand A, signed two's complement.
- b  input  WORD_SIZE  operand B, signed two's complement.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result, rem and flags valid.
- result  output  WORD_SIZE  operation result.
- rem  output  WORD_SIZE  DIV remainder; 0 for all other ops.
- div_zero  output  1  DIV with b=0; valid with done.
- illegal  output  1  unknown func code; valid with done.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk.
- Reset values: busy=0, done=0, result=0, rem=0, div_zero=0, illegal=0, FSM=IDLE, iteration counter=0.
- Reset mid-operation aborts the op immediately; no done pulse follows.
- Function codes:
  - SUB 00000, ADD 00001, MLT 00010, DIV 00011, NOT 00100, AND 00101, OR 00110, XOR 00111.
  - SUL 01000, SSL 01001, SUR 01010, SSR 01011.
  - EQ 10000, NEQ 10001, LT 10010, LEQ 10011.
  - Any other code is illegal.
- Operand capture: func, a and b are latched at the accepting edge E0 (start=1, busy=0). Later input changes have no effect.
- FSM has three states: IDLE, ITER, FINISH.
  - IDLE + start:
    - Single-cycle op, illegal code, or DIV with b=0: compute at E0. done=1 during the cycle after E0, busy stays 0; state stays IDLE.
    - MLT, or DIV with b≠0: busy=1, counter=WORD_SIZE, go to ITER.
  - ITER: one shift-add (MLT) or restoring-subtract (DIV) step per edge on the operand magnitudes. Decrement the counter; go to FINISH when it reaches 0.
  - FINISH: apply sign correction, register result/rem, pulse done, busy=0, go to IDLE.
- Iterative latency: done is high during the cycle after edge E(WORD_SIZE+1), i.e. WORD_SIZE+1 edges after E0.
- Back-to-back issue: start is accepted in the same cycle done is high, since busy=0 then.
- start while busy=1 is ignored; it is not queued.
- Arithmetic rules:
  - ADD, SUB and MLT wrap modulo 2^WORD_SIZE; MLT returns the low WORD_SIZE bits of the signed product.
  - DIV truncates toward zero. rem takes the sign of a; a = result*b + rem holds for all valid cases.
  - MIN_INT / -1 gives result = MIN_INT, rem = 0.
  - DIV with b=0: result = all ones, rem = a, div_zero=1.
  - Shifts use b[SHAMT_BITS-1:0]; upper bits of b are ignored. SUL and SSL are both logical left; SUR is logical right; SSR is arithmetic right.
  - EQ/NEQ/LT/LEQ compare signed and return 0 or 1, zero-extended.
  - NOT returns ~a.
  - Illegal code: result = 0, illegal=1.
- Output holding:
  - result and rem hold their values until the next done.
  - div_zero and illegal are valid only while done=1, and are 0 otherwise.

Test Plan:
- Reset released, then ADD a=7, b=-3 → done 1 cycle after E0, result=4, busy never high; SUB 0-1 → 0xFFFFFFFF.
- MLT a=-6, b=7 with WORD_SIZE=32 → busy for 33 cycles, done at E0+33, result=-42; MLT 0x10000*0x10000 → result=0 (wrap).
- DIV a=-17, b=5 → result=-3, rem=-2. DIV a=0x80000000, b=-1 → result=0x80000000, rem=0. DIV a=9, b=0 → done after 1 cycle, result=0xFFFFFFFF, rem=9, div_zero=1.
- SSR a=0x80000000, b=0x24 (shamt 4) → 0xF8000000. SUR on the same operands → 0x08000000. LT a=-1, b=1 → 1. LEQ a=5, b=5 → 1. func=11111 → result=0, illegal=1.
- DIV in flight, start pulsed at E0+5 with ADD → ignored, DIV result unaffected. New start issued on the done cycle → accepted.
- Assert reset at E0+10 of an MLT → busy=0, done stays 0, result=0. Next ADD 2+2 after release → 4.
- WORD_SIZE=8 instance: MLT -4*3 → 0xF4, done at E0+9. SSL a=0x01, b=0x0F (shamt 7) → 0x80.
